// File: rtl/gng_burst_ctrl.sv
// Burst controller between a noise generator and an AXI-stream style sink.
// Optional gain stage in front of the FIFO is enabled by GNG_BURST_CTRL_GAIN_EN.
module gng_burst_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [15:0]      gain,
    output logic             busy,
    output logic             done,
    output logic             gng_ce,
    input  logic             gng_valid,
    input  logic [15:0]      gng_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [15:0]      m_data,
    output logic             m_last
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [CNT_W-1:0] len_q, issued, xfer;
    logic [CW-1:0]    count, inflight, inflight_nx;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [15:0]      mem [FIFO_DEPTH];
    logic             aborted, done_q;
    logic             rx_vld, rx_cnt;
    logic [15:0]      rx_data;
    logic             push, pop, issue_ok, credit_ok, last_beat, flush;

`ifdef GNG_BURST_CTRL_GAIN_EN
    logic signed [32:0] prod, shr;
    logic [15:0]        scaled;

    // s<16,11> x u<16,14>: sign-extend data, zero-extend gain, floor-shift back to s<16,11>
    always_comb begin
        prod = $signed({{17{gng_data[15]}}, gng_data} * {17'd0, gain});
        shr  = prod >>> 14;
        if (shr > 33'sd32767)
            scaled = 16'h7fff;
        else if (shr < -33'sd32768)
            scaled = 16'h8000;
        else
            scaled = shr[15:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_vld  <= 1'b0;
            rx_data <= '0;
        end else begin
            rx_vld  <= gng_valid && (state != IDLE);
            rx_data <= scaled;
        end
    end
`else
    logic unused_gain;
    assign unused_gain = ^gain;
    assign rx_vld      = gng_valid;
    assign rx_data     = gng_data;
`endif

    // Credit covers both buffered samples and samples still owed by the generator
    assign issue_ok    = (len_q == '0) || (issued < len_q);
    assign credit_ok   = ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
    assign gng_ce      = (state == RUN) && !abort && issue_ok && credit_ok;
    assign rx_cnt      = rx_vld && (state != IDLE);
    assign push        = rx_cnt && !aborted && !abort;
    assign flush       = abort && (state != IDLE);
    assign inflight_nx = inflight + CW'(gng_ce) - CW'(rx_cnt);

    assign m_valid   = (count != '0);
    assign pop       = m_valid && m_ready;
    assign m_data    = m_valid ? mem[rd_ptr] : '0;
    assign last_beat = (len_q != '0) && (xfer == len_q - CNT_W'(1));
    assign m_last    = m_valid && last_beat;
    assign busy      = (state != IDLE);
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            len_q    <= '0;
            issued   <= '0;
            xfer     <= '0;
            inflight <= '0;
            aborted  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            inflight <= inflight_nx;
            if (gng_ce) issued <= issued + CNT_W'(1);
            if (pop)    xfer   <= xfer + CNT_W'(1);
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= RUN;
                        len_q   <= burst_len;
                        issued  <= '0;
                        xfer    <= '0;
                        aborted <= 1'b0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state   <= DRAIN;
                        aborted <= 1'b1;
                    end else if (gng_ce && (len_q != '0) && (issued == len_q - CNT_W'(1))) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // after abort we only wait for the generator to stop owing samples
                    if (aborted) begin
                        if (inflight_nx == '0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end else if (abort) begin
                        aborted <= 1'b1;
                    end else if (pop && last_beat) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
